// File: rtl/pipeline_debug_control_pkg.sv
// ============================================================================
// Module   : pipeline_debug_control_pkg
// Brief    : Shared command/ack bytes, state encoding and default halt word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_debug_control_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_ACK  = 3'd4
   } state_t;

   localparam logic [7:0] c_cmd_load = 8'h4C;
   localparam logic [7:0] c_cmd_run  = 8'h43;
   localparam logic [7:0] c_cmd_step = 8'h53;
   localparam logic [7:0] c_cmd_next = 8'h4E;
   localparam logic [7:0] c_cmd_exit = 8'h45;

   localparam logic [7:0] c_ack_load = 8'h41;
   localparam logic [7:0] c_ack_halt = 8'h48;

   localparam logic [31:0] c_halt_word = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/pipeline_debug_control_byte_assembler.sv
// ============================================================================
// Module   : pipeline_debug_control_byte_assembler
// Brief    : Packs host bytes MSB-first into words, flagging each 4th byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_debug_control_byte_assembler #(
   parameter int LEN = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_byte_valid,
   input  logic [7:0]     i_byte,
   output logic           o_word_valid,
   output logic [LEN-1:0] o_word
);

   // Only the first three bytes need storing; the fourth is taken straight
   // from the input so the word is available in the same cycle.
   logic [LEN-9:0] r_shift;
   logic [1:0]     r_count;
   logic [LEN-1:0] w_word;

   assign w_word       = {r_shift, i_byte};
   assign o_word       = w_word;
   assign o_word_valid = i_byte_valid && (r_count == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_count <= 2'd0;
      end else if (i_byte_valid) begin
         r_shift <= w_word[LEN-9:0];
         r_count <= r_count + 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipeline_debug_control.sv
// ============================================================================
// Module   : pipeline_debug_control
// Brief    : Host-driven program loader and run/step/halt sequencer for the
//            pipeline clock-enable and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_debug_control
   import pipeline_debug_control_pkg::*;
#(
   parameter int             LEN       = 32,
   parameter int             ADDR_W    = 10,
   parameter logic [LEN-1:0] HALT_WORD = LEN'(c_halt_word)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_rx_data,
   input  logic              in_rx_valid,
   input  logic              in_halt,
   input  logic              in_tx_busy,
   output logic [7:0]        out_tx_data,
   output logic              out_tx_start,
   output logic              out_pipe_enable,
   output logic              out_pipe_reset,
   output logic              out_imem_we,
   output logic [ADDR_W-1:0] out_imem_addr,
   output logic [LEN-1:0]    out_imem_data,
   output logic [2:0]        out_state
);

   state_t              r_state, w_state_next;
   logic                r_halted, w_halted_next;
   logic [7:0]          r_ack_byte, w_ack_next;
   logic                r_step_pulse, w_step_fire;
   logic                r_prst_hold;
   logic                r_imem_we;
   logic [ADDR_W-1:0]   r_imem_addr;
   logic [LEN-1:0]      r_imem_data;
   logic                w_word_valid;
   logic [LEN-1:0]      w_word;

   pipeline_debug_control_byte_assembler #(
      .LEN (LEN)
   ) u_byte_assembler (
      .clk          (clk),
      .rst          (reset),
      .i_byte_valid (in_rx_valid && (r_state == ST_LOAD)),
      .i_byte       (in_rx_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_halted_next = r_halted;
      w_ack_next    = r_ack_byte;
      w_step_fire   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_rx_valid) begin
               if (in_rx_data == c_cmd_load) begin
                  w_state_next  = ST_LOAD;
                  w_halted_next = 1'b0;
               end else if (in_rx_data == c_cmd_run && !r_halted) begin
                  w_state_next = ST_RUN;
               end else if (in_rx_data == c_cmd_step && !r_halted) begin
                  w_state_next = ST_STEP;
               end
            end
         end
         ST_LOAD: begin
            if (w_word_valid && (w_word == HALT_WORD)) begin
               w_state_next = ST_ACK;
               w_ack_next   = c_ack_load;
            end
         end
         ST_RUN: begin
            if (in_halt) begin
               w_state_next  = ST_ACK;
               w_ack_next    = c_ack_halt;
               w_halted_next = 1'b1;
            end
         end
         ST_STEP: begin
            // A halt during a step pulse wins over any command in that cycle.
            if (r_step_pulse && in_halt) begin
               w_state_next  = ST_ACK;
               w_ack_next    = c_ack_halt;
               w_halted_next = 1'b1;
            end else if (in_rx_valid) begin
               if (in_rx_data == c_cmd_next) begin
                  w_step_fire = 1'b1;
               end else if (in_rx_data == c_cmd_exit) begin
                  w_state_next = ST_IDLE;
               end else if (in_rx_data == c_cmd_run) begin
                  w_state_next = ST_RUN;
               end
            end
         end
         ST_ACK: begin
            if (!in_tx_busy) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_halted     <= 1'b0;
         r_ack_byte   <= 8'h00;
         r_step_pulse <= 1'b0;
         r_prst_hold  <= 1'b1;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_data  <= '0;
      end else begin
         r_halted     <= w_halted_next;
         r_ack_byte   <= w_ack_next;
         r_step_pulse <= w_step_fire;
         r_prst_hold  <= (r_state == ST_LOAD);
         r_imem_we    <= w_word_valid;
         if (w_word_valid) begin
            r_imem_data <= w_word;
         end
         // Address advances after the write cycle so it stays stable during it.
         if (r_imem_we) begin
            r_imem_addr <= (r_imem_data == HALT_WORD) ? '0
                                                       : r_imem_addr + ADDR_W'(1);
         end
      end
   end

   assign out_pipe_enable = !reset &&
                            (((r_state == ST_RUN) && !in_halt) ||
                             ((r_state == ST_STEP) && r_step_pulse));
   assign out_pipe_reset  = reset || (r_state == ST_LOAD) || r_prst_hold;
   assign out_tx_start    = !reset && (r_state == ST_ACK) && !in_tx_busy;
   assign out_tx_data     = out_tx_start ? r_ack_byte : 8'h00;
   assign out_imem_we     = r_imem_we;
   assign out_imem_addr   = r_imem_addr;
   assign out_imem_data   = r_imem_data;
   assign out_state       = r_state;

endmodule

`default_nettype wire
